logic_unit_arbiter: RTL and testbench

- Shares one registered 32-bit bitwise logic unit (AND/OR/XOR/NOR) between two requesters, e.g. the ALU issue path and the branch/compare helper.
- Round-robin arbitration, valid/ready handshakes on request and response channels.
- Single result register with one result in flight; the response returns to the requester that issued it.
- Sustains one operation per cycle when responses are accepted immediately.

---
 rtl/logic_unit_arbiter_if.sv | 43 ++++
 rtl/logic_unit_arbiter.sv | 103 ++++++++++
 tb/tb_logic_unit_arbiter.sv | 198 +++++++++++++++++++
 3 files changed

// File: rtl/logic_unit_arbiter_if.sv
// Request/response bundle between two requesters and the shared logic unit.
// Requesters use the master modport, the arbiter uses the slave modport.
`timescale 1ns/1ps
interface logic_unit_arbiter_if #(
    parameter int WIDTH = 32
);
    logic             req0_valid;
    logic             req0_ready;
    logic [1:0]       req0_op;
    logic [WIDTH-1:0] req0_a;
    logic [WIDTH-1:0] req0_b;
    logic             rsp0_valid;
    logic             rsp0_ready;
    logic [WIDTH-1:0] rsp0_data;

    logic             req1_valid;
    logic             req1_ready;
    logic [1:0]       req1_op;
    logic [WIDTH-1:0] req1_a;
    logic [WIDTH-1:0] req1_b;
    logic             rsp1_valid;
    logic             rsp1_ready;
    logic [WIDTH-1:0] rsp1_data;

    logic [15:0]      stat_grant0;
    logic [15:0]      stat_grant1;

    modport master (
        output req0_valid, req0_op, req0_a, req0_b, rsp0_ready,
        output req1_valid, req1_op, req1_a, req1_b, rsp1_ready,
        input  req0_ready, rsp0_valid, rsp0_data,
        input  req1_ready, rsp1_valid, rsp1_data,
        input  stat_grant0, stat_grant1
    );

    modport slave (
        input  req0_valid, req0_op, req0_a, req0_b, rsp0_ready,
        input  req1_valid, req1_op, req1_a, req1_b, rsp1_ready,
        output req0_ready, rsp0_valid, rsp0_data,
        output req1_ready, rsp1_valid, rsp1_data,
        output stat_grant0, stat_grant1
    );
endinterface

// File: rtl/logic_unit_arbiter.sv
// Round-robin share of one registered AND/OR/XOR/NOR unit between two requesters.
// Latency: result valid one cycle after the request handshake; one op per cycle sustained.
// Backpressure: new grants only when the slot is free or its result is taken this cycle.
// Optional grant counters are built when LOGIC_ARB_STATS_EN is defined.
`timescale 1ns/1ps
module logic_unit_arbiter #(
    parameter int WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 rst_n,
    logic_unit_arbiter_if.slave  bus
);
    typedef enum logic {IDLE = 1'b0, HOLD = 1'b1} state_t;

    state_t           r_state;
    logic             r_owner;
    logic             r_last_grant;
    logic [WIDTH-1:0] r_result;
    logic             r_rsp0_vld;
    logic             r_rsp1_vld;

    logic             w_owner_rdy;
    logic             w_free;
    logic             w_gnt_vld;
    logic             w_gnt_idx;
    logic [1:0]       w_op;
    logic [WIDTH-1:0] w_a;
    logic [WIDTH-1:0] w_b;
    logic [WIDTH-1:0] w_f;

    assign w_owner_rdy = r_owner ? bus.rsp1_ready : bus.rsp0_ready;
    assign w_free      = (r_state == IDLE) | ((r_state == HOLD) & w_owner_rdy);

    // On a tie the requester that did not win last time goes first.
    assign w_gnt_vld = w_free & (bus.req0_valid | bus.req1_valid);
    assign w_gnt_idx = (bus.req0_valid & bus.req1_valid) ? ~r_last_grant : bus.req1_valid;

    assign bus.req0_ready = w_gnt_vld & ~w_gnt_idx;
    assign bus.req1_ready = w_gnt_vld &  w_gnt_idx;

    assign w_op = w_gnt_idx ? bus.req1_op : bus.req0_op;
    assign w_a  = w_gnt_idx ? bus.req1_a  : bus.req0_a;
    assign w_b  = w_gnt_idx ? bus.req1_b  : bus.req0_b;

    always_comb begin
        w_f = '0;
        case (w_op)
            2'b00:   w_f = w_a & w_b;
            2'b01:   w_f = w_a | w_b;
            2'b10:   w_f = w_a ^ w_b;
            default: w_f = ~(w_a | w_b);
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= IDLE;
            r_owner      <= 1'b0;
            r_last_grant <= 1'b1;
            r_result     <= '0;
            r_rsp0_vld   <= 1'b0;
            r_rsp1_vld   <= 1'b0;
        end else if (w_gnt_vld) begin
            r_state      <= HOLD;
            r_owner      <= w_gnt_idx;
            r_last_grant <= w_gnt_idx;
            r_result     <= w_f;
            r_rsp0_vld   <= ~w_gnt_idx;
            r_rsp1_vld   <=  w_gnt_idx;
        end else if ((r_state == HOLD) && w_owner_rdy) begin
            r_state    <= IDLE;
            r_rsp0_vld <= 1'b0;
            r_rsp1_vld <= 1'b0;
        end
    end

    assign bus.rsp0_valid = r_rsp0_vld;
    assign bus.rsp1_valid = r_rsp1_vld;
    assign bus.rsp0_data  = r_rsp0_vld ? r_result : '0;
    assign bus.rsp1_data  = r_rsp1_vld ? r_result : '0;

`ifdef LOGIC_ARB_STATS_EN
    logic [15:0] r_stat0;
    logic [15:0] r_stat1;

    // Counters saturate rather than wrap so a long run never looks idle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_stat0 <= 16'h0000;
            r_stat1 <= 16'h0000;
        end else begin
            if (bus.req0_ready && (r_stat0 != 16'hFFFF)) r_stat0 <= r_stat0 + 16'd1;
            if (bus.req1_ready && (r_stat1 != 16'hFFFF)) r_stat1 <= r_stat1 + 16'd1;
        end
    end

    assign bus.stat_grant0 = r_stat0;
    assign bus.stat_grant1 = r_stat1;
`else
    assign bus.stat_grant0 = 16'h0000;
    assign bus.stat_grant1 = 16'h0000;
`endif
endmodule

// File: tb/tb_logic_unit_arbiter.sv
// Directed bench for logic_unit_arbiter: reset, single op, alternation, hold-off,
// async reset in flight, tie after reset, single-requester streaming, grant counters.
`timescale 1ns/1ps
module tb_logic_unit_arbiter;
    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_errors;

    logic_unit_arbiter_if #(.WIDTH(32)) bus ();

    logic_unit_arbiter #(.WIDTH(32)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    logic [1:0]  v_op  [4];
    logic [31:0] v_a   [4];
    logic [31:0] v_b   [4];
    logic [31:0] v_exp [4];

    initial begin
        n_checks = 0;
        n_errors = 0;
        v_op[0] = 2'b00; v_a[0] = 32'hFFFF_0000; v_b[0] = 32'h0F0F_0F0F; v_exp[0] = 32'h0F0F_0000;
        v_op[1] = 2'b01; v_a[1] = 32'h0000_0001; v_b[1] = 32'h8000_0000; v_exp[1] = 32'h8000_0001;
        v_op[2] = 2'b10; v_a[2] = 32'hFFFF_FFFF; v_b[2] = 32'h0000_FFFF; v_exp[2] = 32'hFFFF_0000;
        v_op[3] = 2'b11; v_a[3] = 32'hF0F0_F0F0; v_b[3] = 32'h0F0F_0F00; v_exp[3] = 32'h0000_000F;

        bus.req0_valid = 1'b0; bus.req0_op = 2'b00; bus.req0_a = '0; bus.req0_b = '0;
        bus.req1_valid = 1'b0; bus.req1_op = 2'b00; bus.req1_a = '0; bus.req1_b = '0;
        bus.rsp0_ready = 1'b0; bus.rsp1_ready = 1'b0;
        rst_n = 1'b1;
        #2 rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_rsp0_valid", bus.rsp0_valid, 0);
        chk("rst_rsp1_valid", bus.rsp1_valid, 0);
        chk("rst_rsp0_data", bus.rsp0_data, 0);
        chk("rst_rsp1_data", bus.rsp1_data, 0);
        chk("rst_stat0", bus.stat_grant0, 0);
        chk("rst_stat1", bus.stat_grant1, 0);
        rst_n = 1'b1;

        // Single AND from requester 0
        tick();
        bus.req0_valid = 1'b1; bus.req0_op = 2'b00;
        bus.req0_a = 32'hF0F0_00FF; bus.req0_b = 32'h0FF0_FFFF;
        #1;
        chk("and_req0_ready", bus.req0_ready, 1);
        chk("and_req1_ready", bus.req1_ready, 0);
        chk("and_rsp0_valid_early", bus.rsp0_valid, 0);
        tick();
        bus.req0_valid = 1'b0;
        chk("and_rsp0_valid", bus.rsp0_valid, 1);
        chk("and_rsp0_data", bus.rsp0_data, 32'h00F0_00FF);
        chk("and_rsp1_valid", bus.rsp1_valid, 0);
        chk("and_rsp1_data", bus.rsp1_data, 0);
        tick();
        chk("and_held", bus.rsp0_data, 32'h00F0_00FF);
        bus.rsp0_ready = 1'b1;
        tick();
        chk("and_drained", bus.rsp0_valid, 0);

        // Both valid: last grant was 0, so order is 1,0,1,0 with no bubble
        bus.rsp1_ready = 1'b1;
        bus.req0_valid = 1'b1; bus.req0_op = 2'b01; bus.req0_a = 32'h1; bus.req0_b = 32'h2;
        bus.req1_valid = 1'b1; bus.req1_op = 2'b11; bus.req1_a = 32'h0; bus.req1_b = 32'h0;
        #1;
        chk("rr_first_req1_ready", bus.req1_ready, 1);
        chk("rr_first_req0_ready", bus.req0_ready, 0);
        for (int i = 0; i < 4; i++) begin
            tick();
            if ((i % 2) == 0) begin
                chk("rr_rsp1_valid", bus.rsp1_valid, 1);
                chk("rr_rsp1_data", bus.rsp1_data, 32'hFFFF_FFFF);
                chk("rr_rsp0_idle", bus.rsp0_valid, 0);
                chk("rr_next_req0_ready", bus.req0_ready, 1);
            end else begin
                chk("rr_rsp0_valid", bus.rsp0_valid, 1);
                chk("rr_rsp0_data", bus.rsp0_data, 32'h3);
                chk("rr_rsp1_idle", bus.rsp1_valid, 0);
                chk("rr_next_req1_ready", bus.req1_ready, 1);
            end
        end
        bus.req0_valid = 1'b0;
        bus.req1_valid = 1'b0;
        tick();
        chk("rr_drained0", bus.rsp0_valid, 0);
        chk("rr_drained1", bus.rsp1_valid, 0);

        // Owner 0 stalls its response; requester 1 is held off
        bus.rsp0_ready = 1'b0; bus.rsp1_ready = 1'b0;
        bus.req0_valid = 1'b1; bus.req0_op = 2'b10;
        bus.req0_a = 32'hAAAA_AAAA; bus.req0_b = 32'hFFFF_FFFF;
        #1;
        chk("hold_req0_ready", bus.req0_ready, 1);
        tick();
        bus.req0_valid = 1'b0;
        bus.req1_valid = 1'b1; bus.req1_op = 2'b00;
        bus.req1_a = 32'h1234_5678; bus.req1_b = 32'hFFFF_0000;
        for (int k = 0; k < 5; k++) begin
            #1;
            chk("hold_rsp0_valid", bus.rsp0_valid, 1);
            chk("hold_rsp0_data", bus.rsp0_data, 32'h5555_5555);
            chk("hold_req1_blocked", bus.req1_ready, 0);
            tick();
        end
        bus.rsp0_ready = 1'b1;
        #1;
        chk("hold_release_req1_ready", bus.req1_ready, 1);
        tick();
        bus.req1_valid = 1'b0;
        chk("hold_rsp1_valid", bus.rsp1_valid, 1);
        chk("hold_rsp1_data", bus.rsp1_data, 32'h1234_0000);
        chk("hold_rsp0_done", bus.rsp0_valid, 0);

        // Asynchronous reset while requester 1 holds an unaccepted result
        #2 rst_n = 1'b0;
        #1;
        chk("arst_rsp1_valid", bus.rsp1_valid, 0);
        chk("arst_rsp1_data", bus.rsp1_data, 0);
        tick();
        tick();
        rst_n = 1'b1;
        #1;
        chk("arst_no_stale", bus.rsp1_valid, 0);

        // First tie after reset goes to requester 0
        bus.rsp0_ready = 1'b1; bus.rsp1_ready = 1'b1;
        bus.req0_valid = 1'b1; bus.req0_op = 2'b01; bus.req0_a = 32'h1; bus.req0_b = 32'h2;
        bus.req1_valid = 1'b1; bus.req1_op = v_op[0]; bus.req1_a = v_a[0]; bus.req1_b = v_b[0];
        #1;
        chk("tie_req0_ready", bus.req0_ready, 1);
        chk("tie_req1_ready", bus.req1_ready, 0);
        tick();
        chk("tie_rsp0_data", bus.rsp0_data, 32'h3);
        bus.req0_valid = 1'b0;
        #1;
        chk("stream_first_ready", bus.req1_ready, 1);

        // Requester 1 alone streams back-to-back
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("stream_rsp1_valid", bus.rsp1_valid, 1);
            chk("stream_rsp1_data", bus.rsp1_data, v_exp[i]);
            chk("stream_rsp0_idle", bus.rsp0_valid, 0);
            if (i < 3) begin
                bus.req1_op = v_op[i+1]; bus.req1_a = v_a[i+1]; bus.req1_b = v_b[i+1];
                #1;
                chk("stream_req1_ready", bus.req1_ready, 1);
            end else begin
                bus.req1_valid = 1'b0;
            end
        end
        tick();
        chk("stream_drained", bus.rsp1_valid, 0);

`ifdef LOGIC_ARB_STATS_EN
        rst_n = 1'b0;
        #1;
        chk("stat_rst0", bus.stat_grant0, 0);
        rst_n = 1'b1;
        bus.rsp0_ready = 1'b1;
        bus.req0_valid = 1'b1; bus.req0_op = 2'b00;
        repeat (70000) tick();
        bus.req0_valid = 1'b0;
        tick();
        chk("stat_sat0", bus.stat_grant0, 16'hFFFF);
        chk("stat_zero1", bus.stat_grant1, 16'h0000);
`else
        chk("stat_off0", bus.stat_grant0, 16'h0000);
        chk("stat_off1", bus.stat_grant1, 16'h0000);
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
